// File: rtl/display_pkg.sv
// display_pkg: shared FSM state type and seven-segment glyphs (seg[0]=a .. seg[6]=g, active-high)
package display_pkg;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_MINUS = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = GLYPH_0;
      4'd1: glyph = GLYPH_1;
      4'd2: glyph = GLYPH_2;
      4'd3: glyph = GLYPH_3;
      4'd4: glyph = GLYPH_4;
      4'd5: glyph = GLYPH_5;
      4'd6: glyph = GLYPH_6;
      4'd7: glyph = GLYPH_7;
      4'd8: glyph = GLYPH_8;
      4'd9: glyph = GLYPH_9;
      default: glyph = GLYPH_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd8.sv
// bin2bcd8: sequential double-dabble converter, 8 shift-add-3 iterations after start
module bin2bcd8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);
  logic [7:0]  sh;
  logic [2:0]  cnt;
  logic        run;
  logic [11:0] adj;

  // add 3 to every BCD digit that is 5 or more before the next shift
  always_comb begin
    adj = {bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8],
           bcd[7:4]  >= 4'd5 ? bcd[7:4]  + 4'd3 : bcd[7:4],
           bcd[3:0]  >= 4'd5 ? bcd[3:0]  + 4'd3 : bcd[3:0]};
  end

  // done flags the edge on which the eighth and final shift happens
  assign done = run && cnt == 3'd7;

  // load on start, then shift the adjusted BCD and binary registers together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
      cnt <= 3'd0;
      sh  <= 8'd0;
      bcd <= 12'd0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= 3'd0;
      sh  <= bin;
      bcd <= 12'd0;
    end else if (run) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt <= cnt + 3'd1;
      run <= !done;
    end
  end
endmodule

// File: rtl/rotor_display.sv
// rotor_display: shows the encoder count in decimal on a 4-digit multiplexed seven-segment display
module rotor_display
  import display_pkg::*;
#(
  parameter int SCAN_BITS  = 16,
  parameter bit SIGNED     = 1'b0,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       busy
);
  localparam logic [SCAN_BITS+1:0] SCAN_ONE = {{(SCAN_BITS+1){1'b0}}, 1'b1};

  state_t state, state_nx;
  logic              force_q, neg, start, done, lit;
  logic [7:0]        last, mag;
  logic [11:0]       bcd;
  logic [3:0]        dig_h, dig_t, dig_u;
  logic              blank_h, blank_t, neg_d;
  logic [SCAN_BITS+1:0] scan;
  logic [1:0]        sel;
  logic [6:0]        gl;
  logic [3:0]        an_raw;

  assign start = state == IDLE && (force_q || value != last);
  assign mag   = (SIGNED && value[7]) ? -value : value;
  assign sel   = scan[SCAN_BITS+1 -: 2];

  bin2bcd8 u_bcd (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bin(mag),
    .done(done),
    .bcd(bcd)
  );

  // next state: IDLE waits for a change, CONV runs the converter, LOAD commits for one cycle
  always_comb begin
    state_nx = (state == IDLE && start) ? CONV :
               (state == CONV && done)  ? LOAD :
               (state == LOAD)          ? IDLE : state;
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end

  // latch the sampled value and sign on start; busy covers the start edge through the commit edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      force_q <= 1'b1;
      last    <= 8'd0;
      neg     <= 1'b0;
      busy    <= 1'b1;
    end else begin
      busy <= state != IDLE || start;
      if (start) begin
        force_q <= 1'b0;
        last    <= value;
        neg     <= SIGNED & value[7];
      end
    end
  end

  // commit converted digits and leading-zero blank flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_h   <= 4'd0;
      dig_t   <= 4'd0;
      dig_u   <= 4'd0;
      blank_h <= 1'b1;
      blank_t <= 1'b1;
      neg_d   <= 1'b0;
    end else if (state == LOAD) begin
      dig_h   <= bcd[11:8];
      dig_t   <= bcd[7:4];
      dig_u   <= bcd[3:0];
      blank_h <= bcd[11:8] == 4'd0;
      blank_t <= bcd[11:4] == 8'd0;
      neg_d   <= neg;
    end
  end

  // free-running scan counter, independent of conversions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) scan <= '0;
    else scan <= scan + SCAN_ONE;
  end

  // select the glyph and anode for the digit currently being scanned
  always_comb begin
    lit    = (sel == 2'd0) | (sel == 2'd1 & ~blank_t) | (sel == 2'd2 & ~blank_h) | (sel == 2'd3 & neg_d);
    gl     = !lit ? GLYPH_BLANK : sel == 2'd3 ? GLYPH_MINUS :
             glyph(sel == 2'd0 ? dig_u : sel == 2'd1 ? dig_t : dig_h);
    an_raw = lit ? 4'b0001 << sel : 4'b0000;
  end

  // anode and segments registered together so digits switch cleanly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= {4{ACTIVE_LOW}};
      seg <= {8{ACTIVE_LOW}};
    end else begin
      an  <= an_raw ^ {4{ACTIVE_LOW}};
      seg <= {1'b0, gl} ^ {8{ACTIVE_LOW}};
    end
  end
endmodule

// File: tb/tb_rotor_display.sv
// tb_rotor_display: table-driven scoreboard bench for unsigned/active-low and signed/active-high builds
module tb_rotor_display;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] value = 8'd0;
  logic [3:0] an_u, an_s;
  logic [7:0] seg_u, seg_s;
  logic busy_u, busy_s;
  int n_cmp = 0, n_bad = 0;

  typedef struct {logic [7:0] v; int eu; int es;} vec_t;
  vec_t sb[$];

  always #5 clk = ~clk;

  rotor_display #(.SCAN_BITS(2), .SIGNED(1'b0), .ACTIVE_LOW(1'b1)) dut_u (
    .clk(clk), .reset(reset), .value(value), .an(an_u), .seg(seg_u), .busy(busy_u));
  rotor_display #(.SCAN_BITS(2), .SIGNED(1'b1), .ACTIVE_LOW(1'b0)) dut_s (
    .clk(clk), .reset(reset), .value(value), .an(an_s), .seg(seg_s), .busy(busy_s));

  function automatic logic [7:0] glyph_m(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F; 4: return 8'h66;
      5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07; 8: return 8'h7F; 9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // expected {digit3, digit2, digit1, digit0} segments for a displayed number, 0 = dark
  function automatic logic [31:0] pattern(input int n);
    int m, h, t, u;
    m = n < 0 ? -n : n;
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    return {n < 0 ? 8'h40 : 8'h00, h != 0 ? glyph_m(h) : 8'h00,
            (h != 0 || t != 0) ? glyph_m(t) : 8'h00, glyph_m(u)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // count busy cycles until both builds go idle; optionally change value mid-run
  task automatic run_busy(input int late_at, input logic [7:0] late_v, output int cu, output int cs);
    bit ended;
    cu = 0;
    cs = 0;
    ended = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!busy_u && !busy_s) begin
        ended = 1;
        break;
      end
      cu += int'(busy_u);
      cs += int'(busy_s);
      if (k == late_at) value = late_v;
    end
    if (!ended) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_bound: busy still high after 80 cycles, want idle");
    end
  endtask

  // watch one full scan period and record which glyph each digit showed
  task automatic scan_capture(output logic [31:0] cu, output logic [31:0] cs, output logic ok_u, output logic ok_s);
    logic [3:0] ah;
    logic [7:0] sh;
    cu = 0; cs = 0; ok_u = 1; ok_s = 1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      ah = ~an_u; sh = ~seg_u;
      if (ah == 0) ok_u &= (sh == 0);
      else if (!$onehot(ah)) ok_u = 0;
      else for (int i = 0; i < 4; i++) if (ah[i]) cu[i*8 +: 8] = sh;
      ah = an_s; sh = seg_s;
      if (ah == 0) ok_s &= (sh == 0);
      else if (!$onehot(ah)) ok_s = 0;
      else for (int i = 0; i < 4; i++) if (ah[i]) cs[i*8 +: 8] = sh;
    end
  endtask

  task automatic settle_check(input string nm);
    logic [31:0] cu, cs;
    logic ok_u, ok_s;
    vec_t e;
    scan_capture(cu, cs, ok_u, ok_s);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, want an expected entry", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_unsigned"}, cu, pattern(e.eu));
      chk({nm, "_signed"}, cs, pattern(e.es));
      chk({nm, "_blank_dark"}, {30'd0, ok_u, ok_s}, 32'd3);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_an_u"}, {28'd0, an_u}, 32'hF);
    chk({nm, "_seg_u"}, {24'd0, seg_u}, 32'hFF);
    chk({nm, "_an_s"}, {28'd0, an_s}, 32'h0);
    chk({nm, "_seg_s"}, {24'd0, seg_s}, 32'h0);
    chk({nm, "_busy"}, {30'd0, busy_u, busy_s}, 32'd3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int cu, cs, exp_busy, d0;
    logic [3:0] prev;
    bit ord_ok, found;
    tbl = '{'{8'd0, 0, 0}, '{8'd255, 255, -1}, '{8'h80, 128, -128}, '{8'd100, 100, 100},
            '{8'd99, 99, 99}, '{8'd9, 9, 9}, '{8'd10, 10, 10}, '{8'd127, 127, 127},
            '{8'hF6, 246, -10}, '{8'd200, 200, -56}, '{8'd1, 1, 1}, '{8'd0, 0, 0}};

    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset = 1'b0;
    sb.push_back('{8'd0, 0, 0});
    run_busy(-1, 8'd0, cu, cs);
    chk("release_busy_u", cu, 10);
    chk("release_busy_s", cs, 10);
    settle_check("release_zero");

    for (int i = 0; i < 12; i++) begin
      exp_busy = (tbl[i].v != value) ? 10 : 0;
      value = tbl[i].v;
      sb.push_back(tbl[i]);
      run_busy(-1, 8'd0, cu, cs);
      chk($sformatf("busy_u_%0d", tbl[i].v), cu, exp_busy);
      chk($sformatf("busy_s_%0d", tbl[i].v), cs, exp_busy);
      settle_check($sformatf("vec_%0d", tbl[i].v));
    end

    value = 8'd5;
    sb.push_back('{8'd7, 7, 7});
    run_busy(2, 8'd7, cu, cs);
    chk("mid_change_busy", cu, 20);
    settle_check("mid_change");

    value = 8'd42;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset("async_reset");
    value = 8'd170;
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{8'd170, 170, -86});
    run_busy(-1, 8'd0, cu, cs);
    chk("rerelease_busy", cu, 10);
    settle_check("after_reset");

    value = 8'h80;
    sb.push_back('{8'h80, 128, -128});
    run_busy(-1, 8'd0, cu, cs);
    settle_check("minus128");
    prev = an_s;
    found = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (an_s != prev) begin
        found = 1;
        break;
      end
    end
    d0 = 0;
    for (int i = 0; i < 4; i++) if (an_s[i]) d0 = i;
    ord_ok = found;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (an_s != 4'(4'b0001 << ((d0 + k / 4) % 4))) ord_ok = 0;
    end
    chk("scan_order", {31'd0, ord_ok}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rotor_display.md
# rotor_display

Drives a 4-digit multiplexed seven-segment display with the 8-bit count produced by the rotary-encoder decoder, shown in decimal. It sits directly downstream of the encoder decoder and takes its `out` bus unchanged. A sequential binary-to-BCD converter re-runs whenever the input changes. A free-running scan counter time-multiplexes the digits, with leading-zero blanking and an optional signed mode.

## Interface

- `SCAN_BITS`, default 16: digit dwell is 2^SCAN_BITS clk cycles (1.31 ms at 50 MHz).
- `SIGNED`, default 0: 0 shows `value` as 0..255; 1 shows it as two's complement −128..127.
- `ACTIVE_LOW`, default 1: 1 means `an` and `seg` are active-low; 0 means active-high.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high.
- `value`  in  8  count from the encoder decoder; synchronous to clk.
- `an`  out  4  digit enables, one-hot when lit; an[0] is the units digit, an[3] the sign digit.
- `seg`  out  8  segments: seg[0]=a … seg[6]=g; seg[7]=dp, always off.
- `busy`  out  1  high while a conversion is in progress.

## Operation

- **Change detect.** In IDLE, `value != last` starts a conversion. The block also forces one conversion after reset.
- **Latch on start.** On start, `last <= value` and `neg <= SIGNED & value[7]`.
  - `mag` is −value when `neg`, otherwise `value`.
  - Magnitude range is 0..255 unsigned and 0..128 signed; 8'h80 gives mag 128.
- **Conversion FSM.**
  - IDLE: waits for a change or the forced start, then goes to CONV.
  - CONV: 8 iterations of shift-add-3 (double dabble) on a 12-bit BCD register and an 8-bit shift register, then goes to LOAD.
  - LOAD: commits hundreds, tens, units, `neg` and the blank flags to the display registers, then goes to IDLE.
- **Input changes during CONV/LOAD.** These are not sampled. On return to IDLE the comparison is against `last`, so the final settled value is always displayed and no stale value persists.
- **Blanking.**
  - Hundreds is blank when 0.
  - Tens is blank when both hundreds and tens are 0.
  - Units is never blank.
  - Digit 3 shows "−" (segment g only) when `neg`, otherwise it is blank.
  - A blank digit has its anode deasserted and all segments off.
- **Scan.**
  - Free-running counter of SCAN_BITS+2 bits; its top 2 bits select the digit, in order 0,1,2,3 with wrap.
  - Glyphs are the standard 0–9 patterns.
- **Output polarity.** `an` and `seg` are registered and inverted when ACTIVE_LOW.

## Timing

- **Reset values.**
  - All outputs: `an` inactive (4'hF when ACTIVE_LOW), `seg` all off (8'hFF when ACTIVE_LOW), `busy` = 1 (forced conversion pending).
  - Internal state: FSM in IDLE, scan counter 0, `last` = 0.
  - Display registers: units = 0, all other digits blank.
- **Reset release.** The first rising edge after reset deassertion enters CONV.
- **Latency.** `value` changes before edge E. Then:
  - CONV is entered at E.
  - LOAD is entered at E+8.
  - The display registers update at E+9.
  - `an`/`seg` reflect the new digits at E+10 at the earliest (registered output), otherwise at the next dwell of that digit.
- **`busy`.** High from E through E+9; low in IDLE.
- **Digit switching.** `an` and `seg` change on the same edge, so there is no ghosting cycle between digits.
- **Reset mid-conversion.** The partial result is discarded, the outputs return to their reset values, and a new forced conversion starts.
- **Scan counter.** Unaffected by conversions; it wraps from all-ones to 0.

## Structure

- **Shared package `display_pkg`:**
  - FSM state typedef (IDLE, CONV, LOAD).
  - The ten digit glyph constants, `GLYPH_MINUS` and `GLYPH_BLANK` (7-bit, active-high).
- **Sub-module `bin2bcd8`:**
  - Sequential double dabble.
  - Ports: `clk`, `reset`, `start`, `bin[7:0]` in; `done`, `bcd[11:0]` out.
  - Owns the CONV iteration counter.
- **Top level:** owns change detect, sign/magnitude, blanking, scan and output registers.

## Test plan

- Reset, then release with `value` = 0 → after 10 cycles, scanning shows only digit 0 lit with glyph "0"; `an` never enables digits 1–3.
- SIGNED=0, `value` = 255 → display registers become 2,5,5 at E+9; digit 3 stays blank; `busy` is high for exactly 10 cycles.
- SIGNED=1, `value` = 8'hFF → units "1", tens and hundreds blank, digit 3 "−". Then `value` = 8'h80 → shows "−128".
- `value` 5→7 three cycles into a conversion → 5 is committed first, a second conversion starts automatically, and the final display is 7.
- `value` 100→99 → hundreds blanks, tens shows 9. Then 9→10: tens reappears with "1".
- SCAN_BITS=2 → each `an` bit is active for exactly 4 cycles in order 0,1,2,3. Assert reset mid-conversion → outputs go to reset values immediately (asynchronous), and the display shows the current `value` 10 cycles after release.
